fetch_buf_rv: RTL

Parametrised instruction-fetch front end for the RISC-V core. It sits between the core's decode stage and the LLI instruction-memory port. It prefetches sequential words into a DEPTH-entry show-ahead buffer and presents them to decode with a valid/ready handshake. Redirects from the execute stage flush the buffer and discard any in-flight response. It replaces the single-register fetch stage with a configurable-depth buffer, credit-limited request issue and proper output back-pressure.

---
 rtl/fetch_buf_rv.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_buf_rv.sv
// Instruction-fetch front end: sequential prefetch into a show-ahead circular buffer,
// credit-limited LLI request issue, and redirect flush with a one-cycle acknowledge.
module fetch_buf_rv #(
    parameter int unsigned       ADDR_W     = 30,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    // LLI instruction-memory port
    output logic                     lli_re_o,
    output logic [ADDR_W-1:0]        lli_adr_o,
    input  logic [DATA_W-1:0]        lli_dat_i,
    input  logic                     lli_busy_i,
    output logic                     lli_cc_invalidate_o,
    // decode side
    output logic [DATA_W-1:0]        word_o,
    output logic [ADDR_W-1:0]        next_ip_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    // core control
    input  logic                     fence_i_i,
    input  logic                     jump_valid_i,
    input  logic [ADDR_W-1:0]        jump_dst_i,
    output logic                     jump_ready_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic                run_q;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                jr_q, jr_d;

    logic [DATA_W-1:0]   mem_data_q [DEPTH];
    logic [ADDR_W-1:0]   mem_nip_q  [DEPTH];

    logic jump_pend, req_acc, rsp, jump_acc, push, pop, credit;

    // Handshake decode; run_q holds off issue until the first edge after reset release
    always_comb begin
        jump_pend = run_q & jump_valid_i & ~jr_q;
        credit    = (count_q + CntW'(pend_q)) < DepthC;
        lli_re_o  = run_q & ~jump_pend & credit;
        req_acc   = lli_re_o & ~lli_busy_i;
        rsp       = pend_q & ~lli_busy_i;
        jump_acc  = jump_pend & ~lli_busy_i;
        // a response landing in the redirect-accept cycle belongs to the old stream
        push      = rsp & ~jump_acc;
        valid_o   = (count_q != '0);
        pop       = valid_o & ready_i;
    end

    // Next-state for fetch address, outstanding request and buffer bookkeeping
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        jr_d         = jump_acc;
        if (jump_acc) begin
            fetch_addr_d = jump_dst_i;
            pend_d       = 1'b0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (req_acc) begin
                pend_d       = 1'b1;
                pend_addr_d  = fetch_addr_q;
                fetch_addr_d = fetch_addr_q + ADDR_W'(1);
            end else if (rsp) begin
                pend_d = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Control state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q        <= 1'b0;
            fetch_addr_q <= START_ADDR;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            jr_q         <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            fetch_addr_q <= fetch_addr_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            jr_q         <= jr_d;
        end
    end

    // Buffer storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= lli_dat_i;
            mem_nip_q[wr_ptr_q]  <= pend_addr_q + ADDR_W'(1);
        end
    end

    // Outputs; head entry is masked to zero while empty
    always_comb begin
        lli_adr_o           = fetch_addr_q;
        lli_cc_invalidate_o = fence_i_i;
        jump_ready_o        = jr_q;
        level_o             = count_q;
        word_o              = valid_o ? mem_data_q[rd_ptr_q] : '0;
        next_ip_o           = valid_o ? mem_nip_q[rd_ptr_q] : '0;
    end

endmodule
